// File: rtl/kernel_launch_queue.sv
`default_nettype none
// ============================================================================
// Module   : kernel_launch_queue
// Brief    : Buffers host kernel launches and feeds them one at a time to the
//            block dispatcher. Define LAUNCH_TIMEOUT_EN for the RUN watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module kernel_launch_queue #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int CONFIG_W       = 64,
  parameter int NB_W           = 16,
  parameter int DATA_W         = 32
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               host_valid,
  input  logic [CONFIG_W-1:0]                host_config,
  output logic                               host_ready,
  input  logic                               flush,
  output logic                               disp_reset,
  output logic                               disp_start,
  output logic [CONFIG_W-1:0]                disp_config,
  input  logic                               disp_done,
  output logic                               busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]   queue_count,
  output logic [DATA_W-1:0]                  launch_id,
  output logic [DATA_W-1:0]                  kernels_done,
  output logic                               timeout_err
);

  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int c_RST_W = $clog2(RESET_CYCLES + 1);

  if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) ||
      (RESET_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
    $error("kernel_launch_queue: illegal parameter value");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CONFIG_W-1:0] r_mem [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_RST_W-1:0]  r_rst_cnt;
  logic [CONFIG_W-1:0] w_head;
  logic                w_head_zero;
  logic                w_push;
  logic                w_pop;
  logic                w_timeout_hit;

  // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
  assign host_ready  = (r_count != c_CNT_W'(QUEUE_DEPTH));
  assign w_push      = host_valid && host_ready && !flush;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_zero = (w_head[NB_W-1:0] == '0);
  assign queue_count = r_count;
  assign busy        = (r_state != S_IDLE) || (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= host_config;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    disp_reset  = 1'b1;
    disp_start  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && !flush) begin
          w_pop = 1'b1;
          // Zero-block kernels would never finish, so they are retired without launching.
          if (!w_head_zero) w_state_nxt = S_RESET;
        end
      end
      S_RESET: begin
        if (r_rst_cnt == c_RST_W'(RESET_CYCLES - 1)) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        disp_reset = 1'b0;
        disp_start = 1'b1;
        if (disp_done || w_timeout_hit) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rst_cnt    <= '0;
      disp_config  <= '0;
      launch_id    <= '0;
      kernels_done <= '0;
    end else begin
      r_rst_cnt <= (r_state == S_RESET) ? r_rst_cnt + c_RST_W'(1) : '0;
      if (w_pop) begin
        launch_id <= launch_id + DATA_W'(1);
        if (!w_head_zero) disp_config <= w_head;
      end
      if ((w_pop && w_head_zero) || (r_state == S_DRAIN)) begin
        kernels_done <= kernels_done + DATA_W'(1);
      end
    end
  end

`ifdef LAUNCH_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_timeout_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_to_cnt <= (r_state == S_RUN) ? r_to_cnt + c_TO_W'(1) : '0;
      if ((r_state == S_RUN) && !disp_done && w_timeout_hit) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign w_timeout_hit = (r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err   = r_timeout_err;
`else
  assign w_timeout_hit = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_kernel_launch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_kernel_launch_queue
// Brief    : Directed and random checks of kernel_launch_queue against a
//            timestamp-based launch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kernel_launch_queue;

  localparam int QD  = 4;
  localparam int RC  = 2;
  localparam int TO  = 16;
  localparam int CW  = 64;
  localparam int NBW = 16;
  localparam int DW  = 32;
  localparam int QCW = $clog2(QD + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          host_valid = 1'b0;
  logic [CW-1:0] host_config = '0;
  logic          host_ready;
  logic          flush = 1'b0;
  logic          disp_reset;
  logic          disp_start;
  logic [CW-1:0] disp_config;
  logic          disp_done = 1'b0;
  logic          busy;
  logic [QCW-1:0] queue_count;
  logic [DW-1:0] launch_id;
  logic [DW-1:0] kernels_done;
  logic          timeout_err;

  always #5 clk = ~clk;

  kernel_launch_queue #(
    .QUEUE_DEPTH(QD), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO),
    .CONFIG_W(CW), .NB_W(NBW), .DATA_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_config(host_config),
    .host_ready(host_ready), .flush(flush), .disp_reset(disp_reset),
    .disp_start(disp_start), .disp_config(disp_config), .disp_done(disp_done),
    .busy(busy), .queue_count(queue_count), .launch_id(launch_id),
    .kernels_done(kernels_done), .timeout_err(timeout_err)
  );

  int total = 0;
  int bad   = 0;

  // Model: pending queue plus the current kernel described by timestamps.
  logic [CW-1:0] m_q[$];
  bit            m_active;
  logic [CW-1:0] m_cfg;
  int            m_start;
  int            m_done_cyc;
  int            m_lid;
  int            m_kdone;
  bit            m_terr;
  int            cyc;
  int            obs_nb[$];
  bit            prev_start;
  bit            zero_started;

  function automatic bit m_running();
    return m_active && (cyc >= m_start) && (m_done_cyc < 0);
  endfunction

  function automatic bit m_drain();
    return m_active && (m_done_cyc >= 0) && (cyc == m_done_cyc + 1);
  endfunction

  function automatic logic [CW-1:0] mk(input int nb);
    logic [47:0] pay;
    pay = {$urandom(), 16'($urandom())};
    return {pay, NBW'(nb)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("host_ready", host_ready, m_q.size() != QD);
    chk("queue_count", queue_count, m_q.size());
    chk("disp_start", disp_start, m_running());
    chk("disp_reset", disp_reset, !m_running());
    chk("disp_config", disp_config, m_cfg);
    chk("busy", busy, m_active || (m_q.size() != 0));
    chk("launch_id", launch_id, DW'(m_lid));
    chk("kernels_done", kernels_done, DW'(m_kdone));
    chk("timeout_err", timeout_err, m_terr);
    if (disp_start && (disp_config[NBW-1:0] == '0)) zero_started = 1'b1;
    if (disp_start && !prev_start) obs_nb.push_back(int'(disp_config[NBW-1:0]));
    prev_start = disp_start;
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge, then check.
  task automatic step(input bit hv, input logic [CW-1:0] cfg, input bit fl, input bit dd);
    bit run, drn, pushed, popped;
    logic [CW-1:0] h;
    host_valid  = hv;
    host_config = cfg;
    flush       = fl;
    disp_done   = dd;
    run    = m_running();
    drn    = m_drain();
    pushed = hv && (m_q.size() != QD) && !fl;
    popped = !m_active && (m_q.size() != 0) && !fl;
    if (fl) m_q.delete();
    if (popped) begin
      h = m_q.pop_front();
      m_lid++;
      if (h[NBW-1:0] == '0) begin
        m_kdone++;
      end else begin
        m_active   = 1'b1;
        m_cfg      = h;
        m_start    = cyc + 1 + RC;
        m_done_cyc = -1;
      end
    end
    if (pushed) m_q.push_back(cfg);
    if (run && dd) m_done_cyc = cyc;
`ifdef LAUNCH_TIMEOUT_EN
    else if (run && (cyc - m_start == TO - 1)) begin
      m_done_cyc = cyc;
      m_terr     = 1'b1;
    end
`endif
    if (drn) begin
      m_kdone++;
      m_active = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    host_valid = 1'b0;
    flush      = 1'b0;
    disp_done  = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    reset       = 1'b0;
    host_valid  = 1'b0;
    flush       = 1'b0;
    disp_done   = 1'b0;
    host_config = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    m_q.delete();
    m_active = 1'b0; m_cfg = '0; m_start = 0; m_done_cyc = -1;
    m_lid = 0; m_kdone = 0; m_terr = 1'b0; cyc = 0;
    obs_nb.delete(); prev_start = 1'b0; zero_started = 1'b0;
    check_all();
  endtask

  task automatic run_until_idle(input int budget, input int hold);
    for (int n = 0; n < budget; n++) begin
      if (!m_active && (m_q.size() == 0)) break;
      step(1'b0, '0, 1'b0, m_running() && (cyc - m_start >= hold));
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  initial begin
    logic [CW-1:0] cfg;
    int  idx;
    bit  stall, hv, acc;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp_reset", disp_reset, 1'b1);
    chk("rst_disp_start", disp_start, 1'b0);
    chk("rst_host_ready", host_ready, 1'b1);
    chk("rst_queue_count", queue_count, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_kernels_done", kernels_done, 0);
    chk("rst_launch_id", launch_id, 0);
    chk("rst_timeout_err", timeout_err, 1'b0);

    // Single launch with fixed latencies
    do_reset();
    cfg = mk(3);
    for (int i = 0; i < 26; i++) begin
      step(i == 0, cfg, 1'b0, i == 20);
      if (cyc == 3) chk("single_start_c3", disp_start, 1'b0);
      if (cyc == 4) begin
        chk("single_start_c4", disp_start, 1'b1);
        chk("single_nb", disp_config[NBW-1:0], 3);
        chk("single_lid", launch_id, 1);
      end
      if (cyc == 21) chk("single_kdone_c21", kernels_done, 0);
      if (cyc == 22) chk("single_kdone_c22", kernels_done, 1);
    end
    chk("single_busy_end", busy, 1'b0);

    // Backpressure and ordering
    do_reset();
    idx = 1; cfg = mk(1); stall = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if ((idx > 6) && !m_active && (m_q.size() == 0)) break;
      hv  = (idx <= 6);
      if (hv && !host_ready) stall = 1'b1;
      acc = hv && (m_q.size() != QD);
      step(hv, cfg, 1'b0, m_running() && (cyc - m_start >= 6));
      if (acc) begin
        idx++;
        cfg = mk(idx);
      end
    end
    chk("bp_stall_seen", stall, 1'b1);
    chk("bp_dispatch_count", obs_nb.size(), 6);
    for (int i = 0; i < obs_nb.size(); i++) chk("bp_order", obs_nb[i], i + 1);
    chk("bp_kdone", kernels_done, 6);
    chk("bp_lid", launch_id, 6);

    // Zero-block launch is retired without starting
    do_reset();
    step(1'b1, mk(2), 1'b0, 1'b0);
    step(1'b1, mk(0), 1'b0, 1'b0);
    step(1'b1, mk(5), 1'b0, 1'b0);
    run_until_idle(100, 3);
    chk("zero_never_started", zero_started, 1'b0);
    chk("zero_kdone", kernels_done, 3);
    chk("zero_lid", launch_id, 3);
    chk("zero_dispatch_count", obs_nb.size(), 2);

    // Flush during RUN with a simultaneous push
    do_reset();
    step(1'b1, mk(4), 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      if (m_running()) break;
      step(1'b0, '0, 1'b0, 1'b0);
    end
    step(1'b1, mk(1), 1'b0, 1'b0);
    step(1'b1, mk(2), 1'b0, 1'b0);
    chk("flush_pre_count", queue_count, 2);
    step(1'b1, mk(9), 1'b1, 1'b0);
    chk("flush_count", queue_count, 0);
    chk("flush_running", disp_start, 1'b1);
    run_until_idle(100, 4);
    chk("flush_kdone", kernels_done, 1);
    chk("flush_lid", launch_id, 1);

    // Asynchronous reset while a kernel runs
    do_reset();
    step(1'b1, mk(5), 1'b0, 1'b0);
    step(1'b1, mk(6), 1'b0, 1'b0);
    step(1'b1, mk(7), 1'b0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      if (m_running()) break;
      step(1'b0, '0, 1'b0, 1'b0);
    end
    chk("ar_pre_start", disp_start, 1'b1);
    reset = 1'b0;
    #1;
    chk("ar_disp_reset", disp_reset, 1'b1);
    chk("ar_disp_start", disp_start, 1'b0);
    chk("ar_queue_count", queue_count, 0);
    chk("ar_lid", launch_id, 0);
    chk("ar_config", disp_config, 0);
    do_reset();
    repeat (5) step(1'b0, '0, 1'b0, 1'b0);
    chk("ar_queue_lost", busy, 1'b0);

    // Random traffic
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 1) == 1, mk($urandom_range(0, 6)), $urandom_range(0, 24) == 0,
           m_running() ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 5) == 0));
    end
    run_until_idle(400, 2);

`ifdef LAUNCH_TIMEOUT_EN
    // Watchdog: disp_done withheld
    do_reset();
    step(1'b1, mk(7), 1'b0, 1'b0);
    step(1'b1, mk(8), 1'b0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      step(1'b0, '0, 1'b0, 1'b0);
      if (cyc == 19) chk("to_err_c19", timeout_err, 1'b0);
      if (cyc == 20) chk("to_err_c20", timeout_err, 1'b1);
    end
    chk("to_err_sticky", timeout_err, 1'b1);
    chk("to_dispatch_count", obs_nb.size(), 2);
    if (obs_nb.size() == 2) chk("to_next_kernel", obs_nb[1], 8);
    run_until_idle(60, 2);
    chk("to_kdone", kernels_done, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
